// File: rtl/multicycle_control.sv
// Main sequencing FSM for the multicycle CPU: fetch/decode/execute/memory/writeback.
// Controls decode combinationally from the state register; memory waits are bounded by MEM_TIMEOUT.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       IR_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic [3:0] state,
   output logic       fault
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EXEC = 4'd10,
      ADDI_WB   = 4'd11,
      HALT      = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_set;
   logic             wait_st;
   logic             timeout;

   assign wait_st = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
   // The limit only bites when memory is still not ready; a late ready still wins.
   assign timeout = wait_st && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT));

   always_comb begin
      state_d   = state_q;
      fault_set = 1'b0;
      cnt_d     = '0;
      if (wait_st && !mem_ready)
         cnt_d = cnt_q + 1'b1;
      case (state_q)
         FETCH:     if (mem_ready) state_d = DECODE;
         DECODE: begin
            case (op)
               OP_RTYPE:      state_d = EXEC_R;
               OP_LW, OP_SW:  state_d = MEM_ADDR;
               OP_BEQ:        state_d = BRANCH;
               OP_J:          state_d = JUMP;
               OP_ADDI:       state_d = ADDI_EXEC;
               default: begin
                  state_d   = HALT;
                  fault_set = 1'b1;
               end
            endcase
         end
         MEM_ADDR: begin
            if (op == OP_LW)
               state_d = MEM_READ;
            else if (op == OP_SW)
               state_d = MEM_WRITE;
            else begin
               state_d   = HALT;
               fault_set = 1'b1;
            end
         end
         MEM_READ:  if (mem_ready) state_d = MEM_WB;
         MEM_WB:    state_d = FETCH;
         MEM_WRITE: if (mem_ready) state_d = FETCH;
         EXEC_R:    state_d = R_WB;
         R_WB:      state_d = FETCH;
         BRANCH:    state_d = FETCH;
         JUMP:      state_d = FETCH;
         ADDI_EXEC: state_d = ADDI_WB;
         ADDI_WB:   state_d = FETCH;
         HALT:      state_d = HALT;
         default:   state_d = HALT;
      endcase
      if (timeout) begin
         state_d   = HALT;
         fault_set = 1'b1;
         cnt_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         cnt_q   <= '0;
         fault   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault   <= fault | fault_set;
      end
   end

   assign state = state_q;

   // Reset gates every strobe so nothing leaks out while the state register is being cleared.
   always_comb begin
      IR_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = 2'd0;
      pc_source     = 2'd0;
      if (reset) begin
         case (state_q)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'd1;
               IR_write  = mem_ready;
               pc_write  = mem_ready;
            end
            DECODE:    alu_src_b = 2'd3;
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
            end
            MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            EXEC_R: begin
               alu_src_a = 1'b1;
               alu_op    = 2'd2;
            end
            R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'd1;
               pc_write_cond = 1'b1;
               pc_source     = 2'd1;
            end
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'd2;
            end
            ADDI_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
            end
            ADDI_WB:   reg_write = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level expected traces with random ops and memory delays.
module tb_multicycle_control;

   localparam int MT = 15;

   localparam logic [3:0] S_FETCH = 4'd0,  S_DEC = 4'd1,  S_MADDR = 4'd2, S_MRD = 4'd3,
                          S_MWB   = 4'd4,  S_MWR = 4'd5,  S_EXR   = 4'd6, S_RWB = 4'd7,
                          S_BR    = 4'd8,  S_J   = 4'd9,  S_AEX   = 4'd10, S_AWB = 4'd11,
                          S_HALT  = 4'd12;

   // Control vector: IR_write,pc_write,pc_write_cond,i_or_d,mem_read,mem_write,mem_to_reg,
   // reg_dst,reg_write,alu_src_a,alu_src_b,alu_op,pc_source
   function automatic logic [15:0] ctl(input bit ir, pw, pwc, iod, mr, mw, m2r, rd, rw, sa,
                                       input logic [1:0] sb, ao, ps);
      return {ir, pw, pwc, iod, mr, mw, m2r, rd, rw, sa, sb, ao, ps};
   endfunction

   localparam logic [15:0] C_F0   = ctl(0,0,0,0,1,0,0,0,0,0,2'd1,2'd0,2'd0);
   localparam logic [15:0] C_F1   = ctl(1,1,0,0,1,0,0,0,0,0,2'd1,2'd0,2'd0);
   localparam logic [15:0] C_DEC  = ctl(0,0,0,0,0,0,0,0,0,0,2'd3,2'd0,2'd0);
   localparam logic [15:0] C_MADR = ctl(0,0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0);
   localparam logic [15:0] C_MRD  = ctl(0,0,0,1,1,0,0,0,0,0,2'd0,2'd0,2'd0);
   localparam logic [15:0] C_MWB  = ctl(0,0,0,0,0,0,1,0,1,0,2'd0,2'd0,2'd0);
   localparam logic [15:0] C_MWR  = ctl(0,0,0,1,0,1,0,0,0,0,2'd0,2'd0,2'd0);
   localparam logic [15:0] C_EXR  = ctl(0,0,0,0,0,0,0,0,0,1,2'd0,2'd2,2'd0);
   localparam logic [15:0] C_RWB  = ctl(0,0,0,0,0,0,0,1,1,0,2'd0,2'd0,2'd0);
   localparam logic [15:0] C_BR   = ctl(0,0,1,0,0,0,0,0,0,1,2'd0,2'd1,2'd1);
   localparam logic [15:0] C_J    = ctl(0,1,0,0,0,0,0,0,0,0,2'd0,2'd0,2'd2);
   localparam logic [15:0] C_AEX  = ctl(0,0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0);
   localparam logic [15:0] C_AWB  = ctl(0,0,0,0,0,0,0,0,1,0,2'd0,2'd0,2'd0);
   localparam logic [15:0] C_NONE = 16'h0000;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       mem_ready;
   logic       IR_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;
   logic       fault;

   int errors = 0;
   int checks = 0;
   bit exp_fault = 1'b0;

   multicycle_control #(.MEM_TIMEOUT(MT), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .IR_write(IR_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .state(state), .fault(fault)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ctl_now();
      return {IR_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
              reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
   endfunction

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
      end
   endtask

   // One clock: drive inputs just after the edge, compare before the next one.
   task automatic cyc(input logic [5:0] o, input logic rdy, input logic [3:0] st,
                      input logic [15:0] c);
      op        = o;
      mem_ready = rdy;
      @(negedge clk);
      check_eq("state", {12'd0, state}, {12'd0, st});
      check_eq("ctl", ctl_now(), c);
      check_eq("fault", {15'd0, fault}, {15'd0, exp_fault});
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      check_eq({tag, "_state"}, {12'd0, state}, 16'd0);
      check_eq({tag, "_ctl"}, ctl_now(), C_NONE);
      check_eq({tag, "_fault"}, {15'd0, fault}, 16'd0);
   endtask

   task automatic do_reset(input int n);
      mem_ready = 1'b1;
      reset = 1'b0;
      #1;
      chk_reset("rst_async");
      repeat (n) begin
         @(negedge clk);
         chk_reset("rst_hold");
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_fault = 1'b0;
   endtask

   task automatic halt_reset(input logic [5:0] o, input int n);
      repeat (n) cyc(o, 1'($urandom), S_HALT, C_NONE);
      do_reset(2);
   endtask

   // A memory wait of 'delay' unready cycles; more than MT unready cycles means abandonment.
   task automatic mem_wait(input logic [3:0] st, input int delay, input logic [5:0] o,
                           input bit rand_op, input logic [15:0] c0, input logic [15:0] c1,
                           output bit to);
      for (int i = 0; i < delay && i <= MT; i++)
         cyc(rand_op ? 6'($urandom) : o, 1'b0, st, c0);
      if (delay > MT) begin
         to = 1'b1;
         exp_fault = 1'b1;
      end else begin
         to = 1'b0;
         cyc(o, 1'b1, st, c1);
      end
   endtask

   task automatic run_instr(input logic [5:0] o, input int fd, input int md, input int hold);
      bit to;
      mem_wait(S_FETCH, fd, o, 1'b1, C_F0, C_F1, to);
      if (to) begin
         halt_reset(o, hold);
         return;
      end
      cyc(o, 1'($urandom), S_DEC, C_DEC);
      case (o)
         6'h00: begin
            cyc(o, 1'($urandom), S_EXR, C_EXR);
            cyc(o, 1'($urandom), S_RWB, C_RWB);
         end
         6'h23: begin
            cyc(o, 1'($urandom), S_MADDR, C_MADR);
            mem_wait(S_MRD, md, o, 1'b0, C_MRD, C_MRD, to);
            if (to) halt_reset(o, hold);
            else cyc(o, 1'($urandom), S_MWB, C_MWB);
         end
         6'h2B: begin
            cyc(o, 1'($urandom), S_MADDR, C_MADR);
            mem_wait(S_MWR, md, o, 1'b0, C_MWR, C_MWR, to);
            if (to) halt_reset(o, hold);
         end
         6'h04: cyc(o, 1'($urandom), S_BR, C_BR);
         6'h02: cyc(o, 1'($urandom), S_J, C_J);
         6'h08: begin
            cyc(o, 1'($urandom), S_AEX, C_AEX);
            cyc(o, 1'($urandom), S_AWB, C_AWB);
         end
         default: begin
            exp_fault = 1'b1;
            halt_reset(o, hold);
         end
      endcase
   endtask

   function automatic bit legal(input logic [5:0] o);
      return o == 6'h00 || o == 6'h23 || o == 6'h2B || o == 6'h04 || o == 6'h02 || o == 6'h08;
   endfunction

   function automatic int pick_delay();
      int r = $urandom_range(0, 19);
      if (r < 14) return $urandom_range(0, 3);
      if (r < 17) return MT;
      return MT + 1;
   endfunction

   initial begin
      logic [5:0] legal_ops [6];
      logic [5:0] o;
      legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
      reset = 1'b0;
      op = 6'h00;
      mem_ready = 1'b1;
      #1;
      chk_reset("por");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Reset landing in the middle of a lw memory wait
      cyc(6'h23, 1'b1, S_FETCH, C_F1);
      cyc(6'h23, 1'b0, S_DEC, C_DEC);
      cyc(6'h23, 1'b0, S_MADDR, C_MADR);
      cyc(6'h23, 1'b0, S_MRD, C_MRD);
      cyc(6'h23, 1'b0, S_MRD, C_MRD);
      do_reset(3);
      cyc(6'h23, 1'b0, S_FETCH, C_F0);
      run_instr(6'h23, 0, 0, 3);

      // Directed sequences
      run_instr(6'h00, 0, 0, 3);
      run_instr(6'h23, 3, 3, 3);
      run_instr(6'h2B, 0, 0, 3);
      run_instr(6'h04, 0, 0, 3);
      run_instr(6'h02, 0, 0, 3);
      run_instr(6'h08, 0, 0, 3);
      run_instr(6'h3F, 0, 0, 20);
      run_instr(6'h00, MT + 1, 0, 3);
      run_instr(6'h00, MT, 0, 3);
      run_instr(6'h23, 0, MT + 1, 3);
      run_instr(6'h2B, 0, MT, 3);
      run_instr(6'h2B, 0, MT + 1, 3);

      // Randomized instruction stream
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 12) == 0) begin
            do o = 6'($urandom); while (legal(o));
         end else begin
            o = legal_ops[$urandom_range(0, 5)];
         end
         run_instr(o, pick_delay(), pick_delay(), $urandom_range(1, 4));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main sequencing FSM for the multicycle CPU. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the instruction-register load strobe (IR_write), PC update, memory strobes, register-file write and ALU/mux selects. It decodes the 6-bit opcode held in the instruction register and waits on a memory ready handshake, with a timeout.

Parameters:
MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready in any memory state before faulting (1..255)
CNT_W, 8, width of the wait counter; must hold MEM_TIMEOUT

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
op  input  6  opcode from the instruction register (op_out)
mem_ready  input  1  memory completes the current read/write this cycle
IR_write  output  1  load instruction register
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (branch)
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_to_reg  output  1  writeback data: 0=ALUOut, 1=MDR
reg_dst  output  1  destination: 0=rt, 1=rd
reg_write  output  1  register-file write enable
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
alu_op  output  2  0=add, 1=sub, 2=funct-decoded, 3=reserved
pc_source  output  2  0=ALU result, 1=ALUOut, 2=jump target
state  output  4  current state, for debug
fault  output  1  sticky: illegal opcode or memory timeout

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, HALT=12. Codes 13-15 are unreachable and map to HALT on the next edge.
- Reset low (asynchronous): state=FETCH, wait counter=0, fault=0. Every control output is forced to 0 while reset is low, regardless of state. This includes mem_read.
- Controls are combinational decodes of state. Any output not listed for a state is 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - IR_write and pc_write equal mem_ready. They pulse only in the cycle the memory completes.
  - mem_ready=1 → DECODE; otherwise stays in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (precompute branch target). Next state by op:
  - 0x00 → EXEC_R
  - 0x23 or 0x2B → MEM_ADDR
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - 0x08 → ADDI_EXEC
  - any other op → HALT, with fault set.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. op=0x23 → MEM_READ; op=0x2B → MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Waits for mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Waits for mem_ready, then → FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2 → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1 → FETCH.
- JUMP: pc_write=1, pc_source=2 → FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=2, alu_op=0 → ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- HALT: all controls 0. Remains in HALT until reset; fault stays 1.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE, and on every mem_ready=1.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - If the count reaches MEM_TIMEOUT while mem_ready=0 → HALT, fault=1. A request is therefore abandoned after exactly MEM_TIMEOUT+1 unready cycles.
  - If mem_ready=1 arrives in the same cycle the limit is reached, mem_ready wins: normal transition, no fault.
- op is sampled only in DECODE and MEM_ADDR. The IR holds op stable after IR_write, because IR_write is never asserted outside FETCH.
- Reset asserted mid-instruction: immediate return to FETCH. Partial memory or register side effects are not undone; all strobes drop asynchronously.
- Cycle counts with zero-wait memory:
  - R-type, ADDI: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq, j: 3 cycles

Test Plan:
- Reset low for 3 cycles mid-MEM_READ → all outputs 0 and state=0 while low. After release: mem_read=1, IR_write=0 until mem_ready.
- op=0x00, mem_ready tied 1 → states 0,1,6,7,0. One IR_write/pc_write pulse in cycle 0; reg_write=1, reg_dst=1 only in cycle 3.
- op=0x23, mem_ready delayed 3 cycles in both FETCH and MEM_READ → states 0×4,1,2,3×4,4,0. IR_write is high in exactly one cycle; reg_write with mem_to_reg=1 in MEM_WB.
- op=0x2B, then op=0x04, then op=0x02 back-to-back, zero-wait → sw mem_write=1 with i_or_d=1 for one cycle. beq pc_write_cond=1, alu_op=1. j pc_write=1, pc_source=2.
- op=0x3F → DECODE then HALT, fault=1 and stays 1 for 20 cycles; reset clears it.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 → HALT after 16 cycles with fault=1. Repeat with mem_ready=1 on cycle 16 → DECODE, fault=0.
